// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM user-port arbiter.
// Build option: SDRAM_ARB_PRIO0_EN (see rr_arbiter).
package sdram_arb_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int DM_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  // Pointer width that stays legal for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot round-robin grant starting the search at i_ptr.
// SDRAM_ARB_PRIO0_EN: port 0 wins whenever it requests; others rotate.
module rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]            i_req,
  input  logic [ptr_width(N)-1:0] i_ptr,
  output logic [N-1:0]            o_gnt
);

  logic [N-1:0] w_below;
  logic [N-1:0] w_hi;
  logic [N-1:0] w_pick;
  logic [N-1:0] w_rr_gnt;

  // Requests at or above the pointer take precedence; otherwise wrap to the bottom.
  assign w_below  = (N'(1) << i_ptr) - N'(1);
  assign w_hi     = i_req & ~w_below;
  assign w_pick   = (|w_hi) ? w_hi : i_req;
  assign w_rr_gnt = w_pick & (~w_pick + N'(1));

`ifdef SDRAM_ARB_PRIO0_EN
  assign o_gnt = i_req[0] ? N'(1) : w_rr_gnt;
`else
  assign o_gnt = w_rr_gnt;
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one single-beat SDRAM controller user port among NUM_REQ requesters.
// Build option: SDRAM_ARB_PRIO0_EN gives port 0 absolute priority.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                        i_sysclk,
  input  logic                        i_arst,
  input  logic                        i_init_done,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ-1:0]          i_rwb,
  input  logic [NUM_REQ*ADDR_W-1:0]   i_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   i_wdata,
  input  logic [NUM_REQ*DM_W-1:0]     i_dm,
  output logic [NUM_REQ-1:0]          o_gnt,
  output logic [NUM_REQ-1:0]          o_done,
  output logic [DATA_W-1:0]           o_rdata,
  output logic                        o_busy,
  output logic                        o_we,
  output logic                        o_re,
  output logic                        o_last,
  output logic [ADDR_W-1:0]           o_addr,
  output logic [DATA_W-1:0]           o_din,
  output logic [DM_W-1:0]             o_dm,
  input  logic [DATA_W-1:0]           i_dout,
  input  logic                        i_wr_ack,
  input  logic                        i_rd_ack,
  input  logic                        i_rd_valid
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  arb_state_t       r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_next_ptr;
  logic             r_rwb;

  logic [NUM_REQ-1:0] w_gnt;
  logic [PTR_W-1:0]   w_idx   [NUM_REQ+1];
  logic               w_rwb   [NUM_REQ+1];
  logic [ADDR_W-1:0]  w_addr  [NUM_REQ+1];
  logic [DATA_W-1:0]  w_wdata [NUM_REQ+1];
  logic [DM_W-1:0]    w_dm    [NUM_REQ+1];
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [PTR_W-1:0]   w_next_ptr;
  logic               w_can_grant;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  // One-hot grant steers an AND-OR mux and an index encoder, one stage per port.
  assign w_idx[0]   = '0;
  assign w_rwb[0]   = 1'b0;
  assign w_addr[0]  = '0;
  assign w_wdata[0] = '0;
  assign w_dm[0]    = '0;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mux
      assign w_idx[gi+1]   = w_idx[gi]   | (w_gnt[gi] ? PTR_W'(gi) : '0);
      assign w_rwb[gi+1]   = w_rwb[gi]   | (w_gnt[gi] & i_rwb[gi]);
      assign w_addr[gi+1]  = w_addr[gi]  | ({ADDR_W{w_gnt[gi]}} & i_addr[gi*ADDR_W +: ADDR_W]);
      assign w_wdata[gi+1] = w_wdata[gi] | ({DATA_W{w_gnt[gi]}} & i_wdata[gi*DATA_W +: DATA_W]);
      assign w_dm[gi+1]    = w_dm[gi]    | ({DM_W{w_gnt[gi]}} & i_dm[gi*DM_W +: DM_W]);
    end
  endgenerate

  assign w_sel_addr = w_addr[NUM_REQ] & {{(ADDR_W-1){1'b1}}, 1'b0};
  assign w_next_ptr = (w_idx[NUM_REQ] == PTR_W'(NUM_REQ-1)) ? '0
                                                            : w_idx[NUM_REQ] + PTR_W'(1);

  // The o_done cycle is never a grant cycle, so a requester still holding
  // i_req while it sees its done pulse is not served a second time.
  assign w_can_grant = i_init_done && (|i_req) && (o_done == '0);

  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_next_ptr <= '0;
      r_rwb      <= 1'b0;
      o_gnt      <= '0;
      o_done     <= '0;
      o_rdata    <= '0;
      o_busy     <= 1'b0;
      o_we       <= 1'b0;
      o_re       <= 1'b0;
      o_last     <= 1'b0;
      o_addr     <= '0;
      o_din      <= '0;
      o_dm       <= '0;
    end else begin
      o_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_can_grant) begin
            r_rwb      <= w_rwb[NUM_REQ];
            r_next_ptr <= w_next_ptr;
            o_gnt      <= w_gnt;
            o_addr     <= w_sel_addr;
            o_din      <= w_wdata[NUM_REQ];
            o_dm       <= w_dm[NUM_REQ];
            o_we       <= ~w_rwb[NUM_REQ];
            o_re       <= w_rwb[NUM_REQ];
            o_last     <= 1'b1;
            o_busy     <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          // Only the acknowledge matching the access direction is honoured.
          if (!r_rwb && i_wr_ack) begin
            o_we    <= 1'b0;
            o_last  <= 1'b0;
            r_state <= DONE;
          end else if (r_rwb && i_rd_ack) begin
            o_re   <= 1'b0;
            o_last <= 1'b0;
            if (i_rd_valid) begin
              o_rdata <= i_dout;
              r_state <= DONE;
            end else begin
              r_state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (i_rd_valid) begin
            o_rdata <= i_dout;
            r_state <= DONE;
          end
        end
        DONE: begin
          o_done  <= o_gnt;
          o_gnt   <= '0;
          o_busy  <= 1'b0;
          r_ptr   <= r_next_ptr;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
